cmd_frame_parser: RTL and testbench

Byte-stream command deframer for the pen-plotter datapath. It sits directly downstream of the UART receive FIFO: it pops bytes whenever the FIFO is non-empty, hunts for a sync byte, and assembles fixed 7-byte frames into validated plotter commands. Each command is presented to the motion controller on a valid/ready handshake. Checksum and opcode errors are dropped and counted.

---
 rtl/plotter_cmd_pkg.sv | 34 +++
 rtl/cmd_timeout_counter.sv | 31 +++
 rtl/cmd_frame_parser.sv | 175 +++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plotter_cmd_pkg.sv
// Shared types and constants for the pen-plotter command deframer.
package plotter_cmd_pkg;

    // Decoded plotter opcode presented to the motion controller.
    typedef enum logic [2:0] {
        CMD_NONE     = 3'd0,
        CMD_MOVE     = 3'd1,
        CMD_DRAW     = 3'd2,
        CMD_PEN_UP   = 3'd3,
        CMD_PEN_DOWN = 3'd4,
        CMD_HOME     = 3'd5
    } cmd_op_t;

    // Parser position within a frame; ST_OUT holds a decoded command.
    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_OP   = 3'd1,
        ST_XL   = 3'd2,
        ST_XH   = 3'd3,
        ST_YL   = 3'd4,
        ST_YH   = 3'd5,
        ST_CHK  = 3'd6,
        ST_OUT  = 3'd7
    } parser_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam int         FRAME_LEN         = 7;

    // Raw opcode bytes 0x01..0x05 map one-to-one onto cmd_op_t.
    function automatic logic op_is_valid(input logic [7:0] op_byte);
        return (op_byte >= 8'h01) && (op_byte <= 8'h05);
    endfunction

endpackage

// File: rtl/cmd_timeout_counter.sv
// Inter-byte stall counter; only instantiated when CMD_PARSER_TIMEOUT_EN is defined.
// o_expired is high in the cycle the count reaches TIMEOUT_CYCLES-1 while counting.
module cmd_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_expired = i_count_en && (r_count == LIMIT);

    // Count stalled cycles; any consumed byte or leaving the payload restarts it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear || o_expired) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// Byte-stream deframer: hunts for SYNC_BYTE, assembles 7-byte frames
// (SYNC, OP, X_L, X_H, Y_L, Y_H, CHK) and presents validated commands on a
// valid/ready port. Optional inter-byte timeout: define CMD_PARSER_TIMEOUT_EN.
//
// Handshake: cmd_valid is high exactly while the parser sits in ST_OUT; the
// cmd_* fields are stable for that whole time and the command is consumed on a
// rising edge where cmd_valid and cmd_ready are both high. cmd_ready without
// cmd_valid has no effect. No FIFO bytes are popped while cmd_valid is high.
module cmd_frame_parser
    import plotter_cmd_pkg::*;
#(
    parameter int         COORD_WIDTH    = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 100_000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             fifo_pop_data,
    input  logic                   fifo_empty,
    output logic                   fifo_pop,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output cmd_op_t                cmd_op,
    output logic [COORD_WIDTH-1:0] cmd_x,
    output logic [COORD_WIDTH-1:0] cmd_y,
    output logic                   err_pulse,
    output logic [7:0]             err_count,
    output logic [2:0]             dbg_state
);

    parser_state_t          r_state;
    parser_state_t          w_state_next;
    logic                   w_pop;
    logic                   w_frame_ok;
    logic                   w_frame_bad;
    logic                   w_timeout;
    logic [7:0]             r_op;
    logic [7:0]             r_xl;
    logic [7:0]             r_xh;
    logic [7:0]             r_yl;
    logic [7:0]             r_yh;
    logic [7:0]             r_xor;
    cmd_op_t                r_cmd_op;
    logic [COORD_WIDTH-1:0] r_cmd_x;
    logic [COORD_WIDTH-1:0] r_cmd_y;
    logic                   r_err_pulse;
    logic [7:0]             r_err_count;
    logic [15:0]            w_x_full;
    logic [15:0]            w_y_full;

    assign w_x_full  = {r_xh, r_xl};
    assign w_y_full  = {r_yh, r_yl};

    assign fifo_pop  = w_pop;
    assign cmd_valid = (r_state == ST_OUT);
    assign cmd_op    = r_cmd_op;
    assign cmd_x     = r_cmd_x;
    assign cmd_y     = r_cmd_y;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign dbg_state = r_state;

`ifdef CMD_PARSER_TIMEOUT_EN
    logic w_in_payload;
    assign w_in_payload = (r_state != ST_HUNT) && (r_state != ST_OUT);

    cmd_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_clear    (w_pop || !w_in_payload),
        .i_count_en (w_in_payload && fifo_empty),
        .o_expired  (w_timeout)
    );
`else
    // Stalls hold forever; this is constant false and only keeps the parameter referenced.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, pop strobe and frame verdict; only a consumed byte advances the frame.
    always_comb begin
        w_state_next = r_state;
        w_pop        = (r_state != ST_OUT) && !fifo_empty;
        w_frame_ok   = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            ST_HUNT: if (w_pop && (fifo_pop_data == SYNC_BYTE)) w_state_next = ST_OP;
            ST_OP:   if (w_pop) w_state_next = ST_XL;
            ST_XL:   if (w_pop) w_state_next = ST_XH;
            ST_XH:   if (w_pop) w_state_next = ST_YL;
            ST_YL:   if (w_pop) w_state_next = ST_YH;
            ST_YH:   if (w_pop) w_state_next = ST_CHK;
            ST_CHK: begin
                if (w_pop) begin
                    if ((fifo_pop_data == r_xor) && op_is_valid(r_op)) begin
                        w_frame_ok   = 1'b1;
                        w_state_next = ST_OUT;
                    end else begin
                        w_frame_bad  = 1'b1;
                        w_state_next = ST_HUNT;
                    end
                end
            end
            ST_OUT:  if (cmd_ready) w_state_next = ST_HUNT;
            default: w_state_next = ST_HUNT;
        endcase
        if (w_timeout) begin
            w_frame_bad  = 1'b1;
            w_state_next = ST_HUNT;
        end
    end

    // Shadow registers, running XOR, command outputs and error accounting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= '0;
            r_xl        <= '0;
            r_xh        <= '0;
            r_yl        <= '0;
            r_yh        <= '0;
            r_xor       <= '0;
            r_cmd_op    <= CMD_NONE;
            r_cmd_x     <= '0;
            r_cmd_y     <= '0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_frame_bad;
            if (w_frame_bad && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_pop) begin
                case (r_state)
                    ST_OP: begin
                        r_op  <= fifo_pop_data;
                        r_xor <= fifo_pop_data;
                    end
                    ST_XL: begin
                        r_xl  <= fifo_pop_data;
                        r_xor <= r_xor ^ fifo_pop_data;
                    end
                    ST_XH: begin
                        r_xh  <= fifo_pop_data;
                        r_xor <= r_xor ^ fifo_pop_data;
                    end
                    ST_YL: begin
                        r_yl  <= fifo_pop_data;
                        r_xor <= r_xor ^ fifo_pop_data;
                    end
                    ST_YH: begin
                        r_yh  <= fifo_pop_data;
                        r_xor <= r_xor ^ fifo_pop_data;
                    end
                    default: ;
                endcase
            end
            if (w_frame_ok) begin
                r_cmd_op <= cmd_op_t'(r_op[2:0]);
                r_cmd_x  <= w_x_full[COORD_WIDTH-1:0];
                r_cmd_y  <= w_y_full[COORD_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Bench for cmd_frame_parser: directed frame table, multi-cycle corner
// sequences, and a randomized byte stream checked against a stream-scan model.
module tb_cmd_frame_parser;
    import plotter_cmd_pkg::*;

    localparam int CW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    fifo_pop_data = 8'h00;
    logic          fifo_empty = 1'b1;
    logic          fifo_pop;
    logic          cmd_valid;
    logic          cmd_ready = 1'b0;
    cmd_op_t       cmd_op;
    logic [CW-1:0] cmd_x;
    logic [CW-1:0] cmd_y;
    logic          err_pulse;
    logic [7:0]    err_count;
    logic [2:0]    dbg_state;

    cmd_frame_parser #(
        .COORD_WIDTH    (CW),
        .SYNC_BYTE      (8'hAA),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fifo_pop_data (fifo_pop_data),
        .fifo_empty    (fifo_empty),
        .fifo_pop      (fifo_pop),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .err_pulse     (err_pulse),
        .err_count     (err_count),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- FIFO model (first-word-fall-through) ----------------
    logic [7:0] fifo_q[$];

    task automatic refresh_fifo();
        fifo_empty    = (fifo_q.size() == 0);
        fifo_pop_data = fifo_empty ? 8'h00 : fifo_q[0];
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        refresh_fifo();
    endtask

    always @(posedge clk) begin
        if (reset_n && fifo_pop && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
        #1 refresh_fifo();
    end

    // ---------------- monitor + scoreboard ----------------
    logic [34:0] exp_q[$];
    logic [34:0] exp_item;
    logic        use_sb = 1'b0;
    int          cap_cnt = 0;
    logic [2:0]  cap_op = 3'd0;
    logic [15:0] cap_x = 16'h0;
    logic [15:0] cap_y = 16'h0;
    int          pulse_cnt = 0;
    int          pop_in_out = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (err_pulse) pulse_cnt++;
            if (fifo_pop && cmd_valid) pop_in_out++;
            if (cmd_valid && cmd_ready) begin
                cap_cnt++;
                cap_op = cmd_op;
                cap_x  = cmd_x;
                cap_y  = cmd_y;
                if (use_sb) begin
                    if (exp_q.size() == 0) begin
                        check("sb_extra_cmd", 64'd1, 64'd0);
                    end else begin
                        exp_item = exp_q.pop_front();
                        check("sb_cmd", {29'd0, cmd_op, cmd_x, cmd_y}, {29'd0, exp_item});
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (fifo_q.size() == 0 && !cmd_valid && (!use_sb || exp_q.size() == 0)) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) check({name, "_idle_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic push_frame(input logic [71:0] bytes, input int len);
        for (int k = 0; k < len; k++) push_byte(bytes[71-8*k -: 8]);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [3:0]  len;
        logic [71:0] bytes;   // first byte in the top octet
        logic        exp_cmd;
        logic [2:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    // ---------------- reference model: scan a whole byte stream ----------------
    logic [7:0] stream[$];

    function automatic int model_scan();
        int i;
        int errs;
        logic [7:0] chk;
        i = 0;
        errs = 0;
        while (i < stream.size()) begin
            if (stream[i] != 8'hAA) begin
                i++;
            end else if (i + 7 <= stream.size()) begin
                chk = stream[i+1] ^ stream[i+2] ^ stream[i+3] ^ stream[i+4] ^ stream[i+5];
                if (chk == stream[i+6] && stream[i+1] >= 8'd1 && stream[i+1] <= 8'd5)
                    exp_q.push_back({stream[i+1][2:0], stream[i+3], stream[i+2], stream[i+5], stream[i+4]});
                else
                    errs++;
                i += 7;
            end else begin
                break;
            end
        end
        return errs;
    endfunction

    task automatic add_rand_frame(input int kind);
        logic [7:0] op;
        logic [7:0] p[4];
        logic [7:0] chk;
        op = (kind == 3) ? 8'($urandom_range(6, 255)) : 8'($urandom_range(1, 5));
        if (kind == 3 && $urandom_range(0, 3) == 0) op = 8'h00;
        for (int k = 0; k < 4; k++) p[k] = 8'($urandom_range(0, 255));
        chk = op ^ p[0] ^ p[1] ^ p[2] ^ p[3];
        if (kind == 2) chk = chk ^ 8'($urandom_range(1, 255));
        stream.push_back(8'hAA);
        stream.push_back(op);
        for (int k = 0; k < 4; k++) stream.push_back(p[k]);
        stream.push_back(chk);
    endtask

    // ---------------- main test ----------------
    int err_total;
    int base_cap;
    int base_pulse;
    int t0, v1, v2, nv, n, bad, pops, kind, burst, idx, exp_errs;

    initial begin
        vecs[0]  = '{4'd7, {8'hAA, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A, 16'h0}, 1'b1, 3'd2, 16'h1234, 16'h5678, 1'b0};
        vecs[1]  = '{4'd9, {8'h00, 8'hFF, 8'hAA, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05}, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{4'd7, {8'hAA, 8'h01, 8'h10, 8'h00, 8'h20, 8'h00, 8'h00, 16'h0}, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1};
        vecs[3]  = '{4'd7, {8'hAA, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h09, 16'h0}, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1};
        vecs[4]  = '{4'd7, {8'hAA, 8'h03, 8'hAA, 8'h00, 8'hAA, 8'h00, 8'h03, 16'h0}, 1'b1, 3'd3, 16'h00AA, 16'h00AA, 1'b0};
        vecs[5]  = '{4'd7, {8'hAA, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 16'h0}, 1'b1, 3'd1, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[6]  = '{4'd7, {8'hAA, 8'h04, 8'h01, 8'h00, 8'h02, 8'h00, 8'h07, 16'h0}, 1'b1, 3'd4, 16'h0001, 16'h0002, 1'b0};
        vecs[7]  = '{4'd7, {8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0}, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1};
        vecs[8]  = '{4'd7, {8'hAA, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h06, 16'h0}, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1};
        vecs[9]  = '{4'd7, {8'hAA, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h6A, 16'h0}, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1};
        vecs[10] = '{4'd7, {8'hAA, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h27, 16'h0}, 1'b1, 3'd5, 16'hBEEF, 16'hDEAD, 1'b0};
        err_total = 0;

        // Reset values.
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_cmd_x", cmd_x, 0);
        check("rst_cmd_y", cmd_y, 0);
        check("rst_err_pulse", err_pulse, 0);
        check("rst_err_count", err_count, 0);
        check("rst_fifo_pop", fifo_pop, 0);
        check("rst_state", dbg_state, ST_HUNT);

        // Throughput: two prefilled frames, ready held high -> valid at +7 and +15.
        step();
        cmd_ready = 1'b1;
        push_frame(vecs[0].bytes, 7);
        push_frame(vecs[6].bytes, 7);
        t0 = -1; v1 = -1; v2 = -1; nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (t0 < 0 && fifo_pop) t0 = c;
            if (cmd_valid) begin
                nv++;
                if (v1 < 0) v1 = c;
                else if (v2 < 0) v2 = c;
            end
        end
        check("tp_valid_cycles", nv, 2);
        check("tp_first_latency", v1 - t0, 7);
        check("tp_second_latency", v2 - t0, 15);
        check("tp_last_cmd", {cap_op, cap_x, cap_y}, {3'd4, 16'h0001, 16'h0002});

        // Directed table.
        for (int v = 0; v < 11; v++) begin
            base_cap   = cap_cnt;
            base_pulse = pulse_cnt;
            step();
            push_frame(vecs[v].bytes, int'(vecs[v].len));
            wait_idle($sformatf("vec%0d", v), 40);
            if (vecs[v].exp_err) err_total++;
            check($sformatf("vec%0d_cmd_count", v), cap_cnt - base_cap, vecs[v].exp_cmd ? 1 : 0);
            if (vecs[v].exp_cmd)
                check($sformatf("vec%0d_cmd", v), {cap_op, cap_x, cap_y}, {vecs[v].op, vecs[v].x, vecs[v].y});
            check($sformatf("vec%0d_err_pulses", v), pulse_cnt - base_pulse, vecs[v].exp_err ? 1 : 0);
            check($sformatf("vec%0d_err_count", v), err_count, err_total);
        end

        // Backpressure: first command held 20 cycles with no pops, then both drain.
        step();
        cmd_ready = 1'b0;
        base_cap = cap_cnt;
        push_frame(vecs[0].bytes, 7);
        push_frame(vecs[5].bytes, 7);
        n = 0;
        while (!cmd_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", cmd_valid, 1);
        bad = 0; pops = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_pop) pops++;
            if (!cmd_valid || cmd_op != CMD_DRAW || cmd_x != 16'h1234 || cmd_y != 16'h5678) bad++;
        end
        check("bp_no_pop", pops, 0);
        check("bp_cmd_stable", bad, 0);
        check("bp_fifo_held", fifo_q.size(), 7);
        step();
        cmd_ready = 1'b1;
        wait_idle("bp", 40);
        check("bp_cmd_count", cap_cnt - base_cap, 2);
        check("bp_second_cmd", {cap_op, cap_x, cap_y}, {3'd1, 16'hFFFF, 16'hFFFF});

        // Stall mid-frame with FIFO empty.
        step();
        base_cap = cap_cnt;
        push_byte(8'hAA);
        push_byte(8'h01);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cmd_valid) nv++;
        end
        check("stall_no_valid", nv, 0);
`ifdef CMD_PARSER_TIMEOUT_EN
        err_total++;
        check("stall_timeout_err", err_count, err_total);
        step();
        push_frame(vecs[6].bytes, 7);
        wait_idle("stall", 40);
        check("stall_next_cmd", {cap_op, cap_x, cap_y}, {3'd4, 16'h0001, 16'h0002});
`else
        check("stall_err_held", err_count, err_total);
        step();
        push_frame({8'h10, 8'h00, 8'h20, 8'h00, 8'h31, 32'h0}, 5);
        wait_idle("stall", 40);
        check("stall_cmd_count", cap_cnt - base_cap, 1);
        check("stall_resume_cmd", {cap_op, cap_x, cap_y}, {3'd1, 16'h0010, 16'h0020});
`endif

        // Reset mid-frame: partial frame lost, err_count cleared.
        step();
        push_frame(vecs[0].bytes, 4);
        repeat (6) step();
        reset_n = 1'b0;
        fifo_q.delete();
        refresh_fifo();
        @(negedge clk);
        check("rstmid_err_count", err_count, 0);
        check("rstmid_cmd", {cmd_valid, cmd_op, cmd_x, cmd_y}, 36'd0);
        check("rstmid_state", dbg_state, ST_HUNT);
        step();
        reset_n = 1'b1;
        err_total = 0;
        base_cap = cap_cnt;
        base_pulse = pulse_cnt;
        push_frame({8'h78, 8'h56, 8'h0A, 48'h0}, 3);
        push_frame(vecs[6].bytes, 7);
        wait_idle("rstmid", 40);
        check("rstmid_next_cmd_count", cap_cnt - base_cap, 1);
        check("rstmid_next_cmd", {cap_op, cap_x, cap_y}, {3'd4, 16'h0001, 16'h0002});
        check("rstmid_no_err", pulse_cnt - base_pulse, 0);

        // Reset while holding a command in OUT.
        step();
        cmd_ready = 1'b0;
        push_frame(vecs[5].bytes, 7);
        n = 0;
        while (!cmd_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        step();
        reset_n = 1'b0;
        @(negedge clk);
        check("rstout_cmd", {cmd_valid, cmd_op, cmd_x, cmd_y}, 36'd0);
        step();
        reset_n = 1'b1;
        cmd_ready = 1'b1;

        // Randomized stream against the stream-scan model.
        use_sb = 1'b1;
        stream.delete();
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 1) begin
                burst = $urandom_range(1, 3);
                for (int k = 0; k < burst; k++) stream.push_back(8'($urandom_range(0, 255)));
            end else begin
                add_rand_frame(kind);
            end
        end
        for (int k = 0; k < 6; k++) stream.push_back(8'h00);
        exp_errs = model_scan();
        base_pulse = pulse_cnt;
        idx = 0;
        while (idx < stream.size()) begin
            step();
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                burst = $urandom_range(1, 8);
                for (int k = 0; k < burst && idx < stream.size(); k++) begin
                    push_byte(stream[idx]);
                    idx++;
                end
            end
        end
        step();
        cmd_ready = 1'b1;
        wait_idle("rand", 3000);
        err_total += exp_errs;
        check("rand_exp_drained", exp_q.size(), 0);
        check("rand_err_count", err_count, err_total);
        check("rand_err_pulses", pulse_cnt - base_pulse, exp_errs);

        // Saturation of err_count at 255.
        step();
        base_pulse = pulse_cnt;
        for (int k = 0; k < 260; k++) push_frame(vecs[7].bytes, 7);
        wait_idle("sat", 4000);
        err_total += 260;
        check("sat_err_count", err_count, (err_total > 255) ? 255 : err_total);
        check("sat_err_pulses", pulse_cnt - base_pulse, 260);

        check("no_pop_while_valid", pop_in_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
